// File: rtl/imem_boot_fetch_pkg.sv
// ============================================================================
// imem_boot_fetch_pkg : shared opcodes, default words and FSM state encoding
// Revision 1.0
// ============================================================================
`default_nettype none

package imem_boot_fetch_pkg;

    // Top five bits of a 16-bit instruction word
    localparam logic [4:0] OPC_NOP  = 5'h00;
    localparam logic [4:0] OPC_HALT = 5'h01;
    localparam logic [4:0] OPC_LOAD = 5'h09;

    localparam logic [2:0] REG_R0 = 3'd0;
    localparam logic [2:0] REG_R1 = 3'd1;

    localparam logic [15:0] PKG_NOP_WORD  = {OPC_NOP,  11'h000};
    localparam logic [15:0] PKG_HALT_WORD = {OPC_HALT, 11'h000};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_boot_fetch_if.sv
// ============================================================================
// imem_boot_fetch_if : loader stream and IF-stage fetch port bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface imem_boot_fetch_if #(
    parameter int unsigned IW = 16,
    parameter int unsigned AW = 8
);
    logic          ld_valid;
    logic          ld_ready;
    logic [IW-1:0] ld_data;
    logic          ld_last;
    logic          reload;
    logic          fetch_en;
    logic          stall;
    logic          flush;
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          loaded;
    logic [AW:0]   load_count;
    logic          par_err;

    modport master (
        output ld_valid, ld_data, ld_last, reload, fetch_en, stall, flush, pc,
        input  ld_ready, instr, instr_valid, loaded, load_count, par_err
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, reload, fetch_en, stall, flush, pc,
        output ld_ready, instr, instr_valid, loaded, load_count, par_err
    );
endinterface

`default_nettype wire

// File: rtl/imem_boot_fetch_array.sv
// ============================================================================
// imem_array : single-write / single-read RAM with registered, enabled read
// Revision 1.0
// ============================================================================
`default_nettype none

module imem_array #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  wire logic          clk,
    input  wire logic          we_i,
    input  wire logic [AW-1:0] waddr_i,
    input  wire logic [W-1:0]  wdata_i,
    input  wire logic          re_i,
    input  wire logic [AW-1:0] raddr_i,
    output logic      [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read data only advances on an enabled read so the fetch output can hold
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/imem_boot_fetch.sv
// ============================================================================
// imem_boot_fetch : boot-loaded instruction memory with 1-cycle fetch port
// Optional parity protection enabled by defining IMEM_PARITY_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module imem_boot_fetch
    import imem_boot_fetch_pkg::*;
#(
    parameter int unsigned   IW        = 16,
    parameter int unsigned   AW        = 8,
    parameter int unsigned   DEPTH     = 256,
    parameter logic [IW-1:0] NOP_WORD  = IW'(PKG_NOP_WORD),
    parameter logic [IW-1:0] HALT_WORD = IW'(PKG_HALT_WORD)
) (
    input wire logic         clk,
    input wire logic         rst_n,
    imem_boot_fetch_if.slave bus
);

`ifdef IMEM_PARITY_EN
    localparam int unsigned MW = IW + 1;
`else
    localparam int unsigned MW = IW;
`endif

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic          nop_q, nop_d;
    logic          chk_q, chk_d;

    logic          w_ready;
    logic          w_accept;
    logic          w_hit;
    logic          w_re;
    logic          w_bad;
    logic [MW-1:0] w_wdata;
    logic [MW-1:0] w_rdata;

    assign w_ready  = rst_n && !bus.reload && (state_q != ST_RUN);
    assign w_accept = bus.ld_valid && w_ready;
    assign w_hit    = {1'b0, bus.pc} < cnt_q;
    assign w_re     = (state_q == ST_RUN) && !bus.reload && !bus.flush &&
                      !bus.stall && bus.fetch_en && w_hit;

`ifdef IMEM_PARITY_EN
    // Even parity: the stored word including its parity bit XORs to zero
    assign w_wdata = {^bus.ld_data, bus.ld_data};
    assign w_bad   = chk_q && (^w_rdata);
`else
    assign w_wdata = bus.ld_data;
    assign w_bad   = 1'b0;
`endif

    imem_array #(
        .W     (MW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (w_accept),
        .waddr_i (cnt_q[AW-1:0]),
        .wdata_i (w_wdata),
        .re_i    (w_re),
        .raddr_i (bus.pc),
        .rdata_o (w_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        nop_d   = nop_q;
        chk_d   = chk_q;
        if (bus.reload) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            vld_d   = 1'b0;
            nop_d   = 1'b1;
            chk_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    vld_d = 1'b0;
                    nop_d = 1'b1;
                    chk_d = 1'b0;
                    if (w_accept) begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = (bus.ld_last || cnt_q == (AW+1)'(DEPTH - 1))
                                  ? ST_RUN : ST_LOAD;
                    end
                end
                ST_RUN: begin
                    if (bus.flush) begin
                        vld_d = 1'b0;
                        nop_d = 1'b1;
                        chk_d = 1'b0;
                    end else if (bus.stall) begin
                        vld_d = vld_q;
                    end else if (bus.fetch_en) begin
                        vld_d = 1'b1;
                        nop_d = !w_hit;
                        chk_d = w_hit;
                    end else begin
                        vld_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            nop_q   <= 1'b1;
            chk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            nop_q   <= nop_d;
            chk_q   <= chk_d;
        end
    end

    assign bus.ld_ready    = w_ready;
    assign bus.instr       = nop_q ? NOP_WORD : (w_bad ? HALT_WORD : w_rdata[IW-1:0]);
    assign bus.instr_valid = vld_q;
    assign bus.loaded      = (state_q == ST_RUN);
    assign bus.load_count  = cnt_q;
    assign bus.par_err     = w_bad;

endmodule

`default_nettype wire

// File: doc/imem_boot_fetch.md
Name: imem_boot_fetch

Overview:
- Parametrised successor to the fixed-content instruction memory.
- Program image is boot-loaded at run time over a valid/ready stream instead of being hard-coded.
- Serves a registered, 1-cycle-latency fetch port to the pipeline IF stage, with stall and flush.
- Words fetched at or beyond the loaded image length return NOP.

Parameters:
- IW, 16: instruction word width.
- AW, 8: address (PC) width.
- DEPTH, 256: number of words; must be ≤ 2**AW.
- NOP_WORD, 16'h0000: word returned for empty/flushed/out-of-image fetches.
- HALT_WORD, 16'h0800: word substituted on parity error (optional feature).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  loader may transfer.
- ld_data  in  IW  instruction word to store.
- ld_last  in  1  marks final word of the image.
- reload  in  1  discard the image and return to IDLE.
- fetch_en  in  1  request fetch at pc.
- stall  in  1  hold the fetch output.
- flush  in  1  squash the fetch output.
- pc  in  AW  fetch address.
- instr  out  IW  fetched instruction.
- instr_valid  out  1  instr holds a real fetch.
- loaded  out  1  image complete; fetch enabled.
- load_count  out  AW+1  number of words loaded (0..DEPTH).
- par_err  out  1  parity error on the last fetch (feature only; tied 0 otherwise).

Behaviour:
- Reset: the synchronous active-low reset on rst_n, sampled at the rising edge of clk, is fixed.
  - State IDLE; write pointer = 0; load_count = 0; loaded = 0; ld_ready = 0.
  - instr = NOP_WORD; instr_valid = 0; par_err = 0.
  - Memory array is not cleared.
- States: IDLE, LOAD, RUN.
- IDLE: ld_ready = 1.
  - Accepted word (ld_valid & ld_ready) is written to mem[0]; pointer = 1; go to LOAD.
  - If that word also has ld_last = 1, go to RUN instead.
- LOAD: ld_ready = 1; each accepted word is written to mem[ptr], then ptr++ and load_count++.
  - Go to RUN when ld_last is accepted, or when the word at DEPTH-1 is accepted.
  - Words after a full DEPTH are never accepted, because ld_ready drops in RUN.
- RUN: ld_ready = 0; loaded = 1.
- reload (any state): next state IDLE; ptr = 0; load_count = 0; loaded = 0; instr = NOP_WORD; instr_valid = 0.
  - reload has priority over load and fetch activity in the same cycle.
- Fetch port (RUN only), evaluated in priority order each edge:
  1. reload or flush: instr = NOP_WORD, instr_valid = 0.
  2. stall: instr, instr_valid and par_err hold.
  3. fetch_en: instr = (pc < load_count) ? mem[pc] : NOP_WORD; instr_valid = 1. Latency is exactly 1 cycle.
  4. Otherwise: instr_valid = 0; instr holds.
- Outside RUN: fetch_en is ignored; instr = NOP_WORD; instr_valid = 0.
- Address comparison is unsigned at AW+1 bits. When load_count = DEPTH, every in-range pc is valid.
- Write and read of the same address cannot coincide: writes occur only outside RUN.
- Reset mid-load: the partial image is abandoned and load_count returns to 0.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- With the macro defined:
  - Each stored word carries an extra even-parity bit computed on write.
  - On fetch, a parity mismatch sets par_err = 1 for that instr_valid cycle and instr = HALT_WORD.
  - par_err clears on the next non-stalled fetch, flush, or reload.
- Without the macro: no parity storage; par_err is constant 0.

Decomposition:
- Shared package: opcode constants (NOP, HALT, LOAD, ...), register encodings, NOP_WORD/HALT_WORD defaults, and the state encoding for IDLE/LOAD/RUN.
- One natural sub-module: imem_array, a single-write/single-read registered RAM of DEPTH x (IW+parity).
- The FSM and fetch logic stay in the top level.

Test Plan:
- Load 8 words with ld_last on word 7 (word 0 = 16'h4805, word 7 = 16'h0800); fetch pc = 0..9.
  - Expect load_count = 8, loaded = 1.
  - instr = each word one cycle after its request; pc 8 and 9 return 16'h0000 with instr_valid = 1.
- Stream DEPTH = 256 words without ld_last.
  - After word 255: RUN, load_count = 256, ld_ready = 0.
  - Word 256 is held unaccepted; fetch pc = 255 returns the 256th word.
- RUN with fetch pc = 3 then stall for 3 cycles while pc changes to 4.
  - instr stays mem[3] and instr_valid stays 1.
  - Release stall: mem[4] appears next cycle.
- Assert flush and stall together with fetch_en: instr = 16'h0000, instr_valid = 0. Assert reload with fetch_en: state IDLE, loaded = 0, load_count = 0.
- Deassert rst_n after 3 of 5 words are loaded.
  - load_count = 0; state IDLE.
  - Reloading 2 words with ld_last gives load_count = 2.
- IMEM_PARITY_EN: force a bit flip in stored word 2 and fetch pc = 2.
  - instr = 16'h0800, par_err = 1.
  - Next fetch pc = 1 gives par_err = 0.
